// File: rtl/spi_link.sv
// spi_link: SPI mode-0 master and slave engines joined over an internal bus.
// One byte is exchanged full-duplex per transfer; the bus lines are exported for monitoring.
module spi_link #(
  parameter int HALF_PERIOD = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] m_tx_data,
  output logic [7:0] m_rx_data,
  output logic       m_done,
  output logic       busy,
  input  logic [7:0] s_tx_data,
  output logic [7:0] s_rx_data,
  output logic       s_done,
  output logic       sclk,
  output logic       mosi,
  output logic       miso,
  output logic       ss_n
);

  localparam int CW = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] HP_LAST = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] HP_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] HP_ONE  = CW'(1);

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_XFER = 2'd1,
    M_HOLD = 2'd2
  } m_state_e;

  m_state_e          m_state_q, m_state_d;
  logic [CW-1:0]     hp_cnt_q, hp_cnt_d;
  logic [3:0]        m_bit_cnt_q, m_bit_cnt_d;
  logic              sclk_q, sclk_d;
  logic              ss_n_q, ss_n_d;
  logic              busy_q, busy_d;
  logic [7:0]        m_tx_sh_q, m_tx_sh_d;
  logic [7:0]        m_rx_sh_q, m_rx_sh_d;
  logic [7:0]        m_rx_data_q, m_rx_data_d;
  logic              m_done_q, m_done_d;

  logic              s_sclk_prev_q, s_sclk_prev_d;
  logic              s_ss_prev_q, s_ss_prev_d;
  logic [2:0]        s_bit_cnt_q, s_bit_cnt_d;
  logic [7:0]        s_tx_sh_q, s_tx_sh_d;
  logic [6:0]        s_rx_sh_q, s_rx_sh_d;
  logic [7:0]        s_rx_data_q, s_rx_data_d;
  logic              s_done_q, s_done_d;

  logic              mosi_s;
  logic              miso_s;

  // MSB of each transmit shifter is the line it drives; the slave releases MISO while deselected.
  assign mosi_s = m_tx_sh_q[7];
  assign miso_s = s_tx_sh_q[7] & ~ss_n_q;

  // Master next-state: SCLK toggles every HALF_PERIOD cycles, sampling on rises, shifting on falls.
  always_comb begin
    m_state_d   = m_state_q;
    hp_cnt_d    = hp_cnt_q;
    m_bit_cnt_d = m_bit_cnt_q;
    sclk_d      = sclk_q;
    ss_n_d      = ss_n_q;
    busy_d      = busy_q;
    m_tx_sh_d   = m_tx_sh_q;
    m_rx_sh_d   = m_rx_sh_q;
    m_rx_data_d = m_rx_data_q;
    m_done_d    = 1'b0;
    case (m_state_q)
      M_IDLE: begin
        if (start) begin
          m_state_d   = M_XFER;
          hp_cnt_d    = HP_ZERO;
          m_bit_cnt_d = 4'd0;
          ss_n_d      = 1'b0;
          busy_d      = 1'b1;
          m_tx_sh_d   = m_tx_data;
        end else begin
          sclk_d = 1'b0;
          ss_n_d = 1'b1;
        end
      end
      M_XFER: begin
        if (hp_cnt_q != HP_LAST) begin
          hp_cnt_d = hp_cnt_q + HP_ONE;
        end else if (!sclk_q) begin
          hp_cnt_d    = HP_ZERO;
          sclk_d      = 1'b1;
          m_rx_sh_d   = {m_rx_sh_q[6:0], miso_s};
          m_bit_cnt_d = m_bit_cnt_q + 4'd1;
        end else if (m_bit_cnt_q == 4'd8) begin
          hp_cnt_d    = HP_ZERO;
          sclk_d      = 1'b0;
          ss_n_d      = 1'b1;
          busy_d      = 1'b0;
          m_tx_sh_d   = 8'h00;
          m_rx_data_d = m_rx_sh_q;
          m_done_d    = 1'b1;
          m_state_d   = M_HOLD;
        end else begin
          hp_cnt_d  = HP_ZERO;
          sclk_d    = 1'b0;
          m_tx_sh_d = {m_tx_sh_q[6:0], 1'b0};
        end
      end
      M_HOLD: begin
        if (start) begin
          m_state_d = M_HOLD;
        end else begin
          m_state_d = M_IDLE;
        end
      end
      default: begin
        m_state_d = M_IDLE;
        sclk_d    = 1'b0;
        ss_n_d    = 1'b1;
        busy_d    = 1'b0;
        m_tx_sh_d = 8'h00;
      end
    endcase
  end

  // Master state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state_q   <= M_IDLE;
      hp_cnt_q    <= HP_ZERO;
      m_bit_cnt_q <= 4'd0;
      sclk_q      <= 1'b0;
      ss_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      m_tx_sh_q   <= 8'h00;
      m_rx_sh_q   <= 8'h00;
      m_rx_data_q <= 8'h00;
      m_done_q    <= 1'b0;
    end else begin
      m_state_q   <= m_state_d;
      hp_cnt_q    <= hp_cnt_d;
      m_bit_cnt_q <= m_bit_cnt_d;
      sclk_q      <= sclk_d;
      ss_n_q      <= ss_n_d;
      busy_q      <= busy_d;
      m_tx_sh_q   <= m_tx_sh_d;
      m_rx_sh_q   <= m_rx_sh_d;
      m_rx_data_q <= m_rx_data_d;
      m_done_q    <= m_done_d;
    end
  end

  // Slave next-state: bus edges are found by comparing the lines against last cycle's copies.
  always_comb begin
    s_sclk_prev_d = sclk_q;
    s_ss_prev_d   = ss_n_q;
    s_bit_cnt_d   = s_bit_cnt_q;
    s_tx_sh_d     = s_tx_sh_q;
    s_rx_sh_d     = s_rx_sh_q;
    s_rx_data_d   = s_rx_data_q;
    s_done_d      = 1'b0;
    if (ss_n_q) begin
      s_tx_sh_d = 8'h00;
    end else if (s_ss_prev_q) begin
      s_tx_sh_d   = s_tx_data;
      s_bit_cnt_d = 3'd0;
    end else if (sclk_q && !s_sclk_prev_q) begin
      s_rx_sh_d   = {s_rx_sh_q[5:0], mosi_s};
      s_bit_cnt_d = s_bit_cnt_q + 3'd1;
      if (s_bit_cnt_q == 3'd7) begin
        s_rx_data_d = {s_rx_sh_q, mosi_s};
        s_done_d    = 1'b1;
      end else begin
        s_rx_data_d = s_rx_data_q;
      end
    end else if (!sclk_q && s_sclk_prev_q) begin
      s_tx_sh_d = {s_tx_sh_q[6:0], 1'b0};
    end else begin
      s_tx_sh_d = s_tx_sh_q;
    end
  end

  // Slave registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_sclk_prev_q <= 1'b0;
      s_ss_prev_q   <= 1'b1;
      s_bit_cnt_q   <= 3'd0;
      s_tx_sh_q     <= 8'h00;
      s_rx_sh_q     <= 7'h00;
      s_rx_data_q   <= 8'h00;
      s_done_q      <= 1'b0;
    end else begin
      s_sclk_prev_q <= s_sclk_prev_d;
      s_ss_prev_q   <= s_ss_prev_d;
      s_bit_cnt_q   <= s_bit_cnt_d;
      s_tx_sh_q     <= s_tx_sh_d;
      s_rx_sh_q     <= s_rx_sh_d;
      s_rx_data_q   <= s_rx_data_d;
      s_done_q      <= s_done_d;
    end
  end

  assign m_rx_data = m_rx_data_q;
  assign m_done    = m_done_q;
  assign busy      = busy_q;
  assign s_rx_data = s_rx_data_q;
  assign s_done    = s_done_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_s;
  assign miso      = miso_s;
  assign ss_n      = ss_n_q;

endmodule

// File: tb/tb_spi_link.sv
// Bench for spi_link: two instances (HALF_PERIOD 2 and 3) checked against a bus-level
// model of a mode-0 byte exchange built from bit timing and expected byte swaps.
module tb_spi_link;

  logic       clk;
  logic       rst;
  logic       start_a   [2];
  logic [7:0] m_tx_a    [2];
  logic [7:0] s_tx_a    [2];
  logic [7:0] m_rx_a    [2];
  logic [7:0] s_rx_a    [2];
  logic       m_done_a  [2];
  logic       s_done_a  [2];
  logic       busy_a    [2];
  logic       sclk_a    [2];
  logic       mosi_a    [2];
  logic       miso_a    [2];
  logic       ss_n_a    [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cur_d   = 0;

  spi_link #(.HALF_PERIOD(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_a[0]), .m_tx_data(m_tx_a[0]),
    .m_rx_data(m_rx_a[0]), .m_done(m_done_a[0]), .busy(busy_a[0]),
    .s_tx_data(s_tx_a[0]), .s_rx_data(s_rx_a[0]), .s_done(s_done_a[0]),
    .sclk(sclk_a[0]), .mosi(mosi_a[0]), .miso(miso_a[0]), .ss_n(ss_n_a[0])
  );

  spi_link #(.HALF_PERIOD(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start_a[1]), .m_tx_data(m_tx_a[1]),
    .m_rx_data(m_rx_a[1]), .m_done(m_done_a[1]), .busy(busy_a[1]),
    .s_tx_data(s_tx_a[1]), .s_rx_data(s_rx_a[1]), .s_done(s_done_a[1]),
    .sclk(sclk_a[1]), .mosi(mosi_a[1]), .miso(miso_a[1]), .ss_n(ss_n_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (dut hp=%0d): got 0x%0h, expected 0x%0h", tag, cur_d + 2, got, exp);
    end
  endtask

  task automatic check_reset(input int d, input string tag);
    cur_d = d;
    check_val(tag, {ss_n_a[d], sclk_a[d], mosi_a[d], miso_a[d], busy_a[d],
                    m_done_a[d], s_done_a[d], m_rx_a[d], s_rx_a[d]},
              {7'b1000000, 16'h0000});
  endtask

  // One transfer observed cycle by cycle from the bus; expectations come from the byte
  // swap, mode-0 bit timing (2*HP cycles per bit) and the stated latencies.
  task automatic run_xfer(input int d, input logic [7:0] mt, input logic [7:0] st,
                          input int hold, input int len);
    int hp, rises, ssl, busy_n, md_n, sd_n, md_at, sd_at, ss_falls;
    int mosi_hi, miso_hi, unstable, rise_at;
    logic [7:0] mbits, sbits;
    logic sclk_p, ss_p, mosi_p;
    hp = d + 2;
    cur_d = d;
    rises = 0; ssl = 0; busy_n = 0; md_n = 0; sd_n = 0; md_at = -1; sd_at = -1;
    ss_falls = 0; mosi_hi = 0; miso_hi = 0; unstable = 0; rise_at = -10;
    mbits = 8'h00; sbits = 8'h00; sclk_p = 1'b0; ss_p = 1'b1; mosi_p = 1'b0;
    m_tx_a[d] = mt;
    s_tx_a[d] = st;
    start_a[d] = 1'b1;
    @(posedge clk);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0) m_tx_a[d] = 8'($urandom);
      if (i == 1) s_tx_a[d] = 8'($urandom);
      if (sclk_a[d] && !sclk_p) begin
        rises++;
        mbits = {mbits[6:0], mosi_a[d]};
        sbits = {sbits[6:0], miso_a[d]};
        rise_at = i;
        if (mosi_a[d] !== mosi_p) unstable++;
      end
      if (i == rise_at + 1 && mosi_a[d] !== mosi_p) unstable++;
      if (!ss_n_a[d]) ssl++;
      if (ss_p && !ss_n_a[d]) ss_falls++;
      if (busy_a[d]) busy_n++;
      if (mosi_a[d]) mosi_hi++;
      if (miso_a[d]) miso_hi++;
      if (m_done_a[d]) begin
        md_n++;
        if (md_at < 0) md_at = i;
      end
      if (s_done_a[d]) begin
        sd_n++;
        if (sd_at < 0) sd_at = i;
      end
      sclk_p = sclk_a[d];
      ss_p   = ss_n_a[d];
      mosi_p = mosi_a[d];
      if (i == hold - 1) start_a[d] = 1'b0;
    end
    check_val("m_rx_data", m_rx_a[d], st);
    check_val("s_rx_data", s_rx_a[d], mt);
    check_val("mosi_bits", mbits, mt);
    check_val("miso_bits", sbits, st);
    check_val("sclk_pulses", rises, 8);
    check_val("ss_low_cycles", ssl, 16 * hp);
    check_val("busy_cycles", busy_n, 16 * hp);
    check_val("ss_falls", ss_falls, 1);
    check_val("m_done_count", md_n, 1);
    check_val("m_done_at", md_at, 16 * hp);
    check_val("s_done_count", sd_n, 1);
    check_val("s_done_at", sd_at, 15 * hp + 1);
    check_val("mosi_high_cycles", mosi_hi, 2 * hp * $countones(mt));
    check_val("miso_high_cycles", miso_hi, 2 * hp * $countones(st) - int'(st[0]));
    check_val("mosi_unstable", unstable, 0);
  endtask

  // Start a transfer, let it run for 4 SCLK periods, then hit reset mid-flight.
  task automatic abort_xfer(input int d, input logic [7:0] mt, input logic [7:0] st);
    int hp;
    hp = d + 2;
    m_tx_a[d] = mt;
    s_tx_a[d] = st;
    start_a[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a[d] = 1'b0;
    repeat (8 * hp - 1) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset(d, "abort_reset_values");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, b;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_a[d] = 1'b0;
      m_tx_a[d]  = 8'h00;
      s_tx_a[d]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    check_reset(0, "reset_state");
    check_reset(1, "reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_reset(0, "idle_after_reset");

    run_xfer(0, 8'h86, 8'h4F, 2, 36);
    run_xfer(0, 8'h80, 8'h01, 2, 36);
    run_xfer(0, 8'h00, 8'hFF, 33, 34);
    run_xfer(0, 8'hFF, 8'h00, 33, 34);
    run_xfer(0, 8'hA5, 8'h5A, 33, 34);
    run_xfer(0, 8'h5A, 8'hA5, 2, 36);
    run_xfer(0, 8'hC3, 8'h3C, 100, 104);
    run_xfer(0, 8'h3C, 8'hC3, 2, 36);

    abort_xfer(0, 8'h12, 8'h34);
    run_xfer(0, 8'hE7, 8'h18, 2, 36);

    for (int n = 0; n < 6; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      run_xfer(0, a, b, int'($urandom_range(1, 5)), 36);
    end

    run_xfer(1, 8'h3C, 8'hC3, 2, 52);
    abort_xfer(1, 8'h99, 8'h66);
    run_xfer(1, 8'h00, 8'hFF, 49, 50);
    for (int n = 0; n < 3; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      run_xfer(1, a, b, int'($urandom_range(1, 5)), 52);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_link.md
Name: spi_link

Overview:
- Self-contained SPI point-to-point link: one SPI master engine and one SPI slave engine, wired together internally over SCLK/MOSI/MISO/SS_n.
- One byte is exchanged full-duplex per transfer: the master's byte goes to the slave and the slave's byte goes to the master.
- Used as the reference SPI transport block. The bus lines are exported for monitoring only.

Parameters:
- HALF_PERIOD, 2, clk cycles per SCLK half-period. Legal values are 2 or more; SCLK period = 2*HALF_PERIOD clk cycles.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  transfer request, level-sampled while idle
- m_tx_data  in  8  byte the master sends, latched at transfer start
- m_rx_data  out  8  byte received by the master
- m_done  out  1  one-cycle pulse when m_rx_data is updated
- busy  out  1  high while the master transfer is in progress
- s_tx_data  in  8  byte the slave sends, latched when the slave detects SS_n falling
- s_rx_data  out  8  byte received by the slave
- s_done  out  1  one-cycle pulse when s_rx_data is updated
- sclk  out  1  monitor copy of SCLK
- mosi  out  1  monitor copy of MOSI
- miso  out  1  monitor copy of MISO
- ss_n  out  1  monitor copy of the slave select (active low)

Behaviour:
- Protocol
  - SPI mode 0: CPOL=0, CPHA=0, MSB first, 8 bits per transfer.
  - Data changes on SCLK falling edges (and on SS_n assertion for bit 7); data is sampled on SCLK rising edges.
- Reset (async, rst=1)
  - Master in IDLE; slave in IDLE.
  - ss_n=1, sclk=0, mosi=0, miso=0, busy=0, m_done=0, s_done=0, m_rx_data=0, s_rx_data=0.
  - Asserting rst mid-transfer aborts immediately to these values.
- Master FSM: IDLE -> XFER -> HOLD -> IDLE.
  - IDLE: sclk=0, ss_n=1.
  - At edge k with start=1: latch m_tx_data, ss_n<=0, mosi<=bit7, busy<=1, go to XFER.
  - XFER: sclk rises at k+HP, k+3HP, ... and falls at k+2HP, ... (HP = HALF_PERIOD).
    - On each rising edge the master shifts miso into its receive register.
    - On falls 1..7 it drives the next bit on mosi.
    - At k+16HP (the 8th fall): sclk<=0, ss_n<=1, mosi<=0, busy<=0, m_rx_data<=received byte, m_done=1 for one cycle; go to HOLD.
  - HOLD: stay while start=1; go to IDLE when start=0. A held start never retriggers a transfer; a new start is accepted in IDLE only.
  - start is ignored in XFER and HOLD. m_tx_data changes after latch have no effect on the current transfer.
- Slave
  - Synchronous to clk; detects edges by comparing current sclk/ss_n against registered copies.
  - SS_n falling detected (k+1): latch s_tx_data, drive miso=bit7, clear bit count.
  - SCLK rise detected: shift mosi into the receive register. On the 8th such sample (k+15HP+1), set s_rx_data and pulse s_done for one cycle.
  - SCLK fall detected: drive the next bit on miso.
  - miso=0 whenever ss_n=1.
  - SS_n rising before 8 bits: abort, s_rx_data unchanged, no s_done.
- Timing margins (HP>=2)
  - MISO settles one cycle after each fall, before the master samples at the next rise.
  - MOSI stays stable through the slave's delayed sample.
- Latency
  - start sampled at k -> s_done at k+15HP+1, m_done at k+16HP.
  - HP=2: s_done at k+31, m_done at k+32.
- Boundary patterns
  - 8'h00 and 8'hFF must round-trip intact.
  - Back-to-back transfers: start low for 1 cycle in HOLD, then high -> next transfer starts at the next IDLE cycle.

Test Plan:
- rst, then m_tx=134 (8'h86), s_tx=79 (8'h4F), start high for 2 clk cycles -> after m_done: m_rx_data=79, s_rx_data=134; exactly 8 sclk pulses; ss_n low for 32 cycles; m_done at k+32.
- MSB-first/mode-0 check, m_tx=8'h80, s_tx=8'h01 -> mosi high only for the first bit period; miso high only for the last; mosi stable at every sclk rise.
- start held high for 100 cycles -> exactly one transfer; second transfer only after start drops and rises again.
- Patterns 8'h00/8'hFF and 8'hA5/8'h5A in back-to-back transfers -> each exchange correct; m_done and s_done each one cycle wide per transfer.
- rst asserted after 4 sclk pulses -> outputs immediately at reset values; the next full transfer exchanges correctly.
- HALF_PERIOD=3, m_tx=8'h3C, s_tx=8'hC3 -> sclk period 6 cycles; m_done at k+48; bytes exchanged correctly.
